// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - encodings and decode helpers for the multi-cycle MIPS control FSM
// Purpose: state encodings, opcode/funct constants, ALUOp codes, mux-select
//          encodings and the packed control bundle shared by decode and top.
// Ports:   none (package).
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // ALUOp = {unsigned, class}
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b100;
    localparam logic [2:0] ALU_ADDIU = 3'b101;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_RS    = 2'd1;
    localparam logic [1:0] SRCA_SHAMT = 2'd2;

    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_S2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_RS     = 2'd3;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic       reg_write;
        logic       ext_op;
        logic       lui_op;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    function automatic logic [3:0] alu_op(input logic uns, input logic [2:0] cls);
        return {uns, cls};
    endfunction

    function automatic logic is_shift(input logic [5:0] fn);
        return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
    endfunction

    function automatic logic is_r_alu(input logic [5:0] fn);
        case (fn)
            FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
            FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE: return is_r_alu(fn) || (fn == FN_JR) || (fn == FN_JALR);
            OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_LUI, OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OP_ADDIU: return alu_op(1'b1, ALU_ADDIU);
            OP_ANDI:  return alu_op(1'b0, ALU_AND);
            OP_SLTI:  return alu_op(1'b0, ALU_SLT);
            OP_SLTIU: return alu_op(1'b1, ALU_SLT);
            default:  return alu_op(1'b0, ALU_ADD);
        endcase
    endfunction

endpackage

// File: rtl/multi_cycle_controller_if.sv
// rtl/multi_cycle_controller_if.sv - controller <-> datapath control bus
// Purpose: groups the instruction fields fed to the controller and every
//          datapath select / write enable it drives.
// Modports: master = controller (reads OpCode/Funct, drives controls),
//           slave  = datapath (drives OpCode/Funct, reads controls).
interface multi_cycle_controller_if;
    logic [5:0] OpCode;
    logic [5:0] Funct;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] MemtoReg;
    logic [1:0] RegDst;
    logic       RegWrite;
    logic       ExtOp;
    logic       LuiOp;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUOp;
    logic [1:0] PCSource;
    logic       Illegal;

    modport master (
        input  OpCode, Funct,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ExtOp, LuiOp, ALUSrcA, ALUSrcB,
               ALUOp, PCSource, Illegal
    );

    modport slave (
        output OpCode, Funct,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ExtOp, LuiOp, ALUSrcA, ALUSrcB,
               ALUOp, PCSource, Illegal
    );
endinterface

// File: rtl/controller_decode.sv
// rtl/controller_decode.sv - combinational decode: {state, OpCode, Funct} -> controls, next state
// Purpose: all output and transition logic of the control FSM.
// Ports:   state_i current state; opcode_i/funct_i from IR;
//          ctrl_o control bundle; next_state_o next FSM state.
// Macro:   CTRL_ILLEGAL_TRAP_EN routes unrecognized instructions to TRAP.
module controller_decode
    import ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output ctrl_t      ctrl_o,
    output state_t     next_state_o
);

    always_comb begin
        ctrl_o       = '0;
        next_state_o = S_IF;
        case (state_i)
            S_IF: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.alu_src_a = SRCA_PC;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = alu_op(1'b0, ALU_ADD);
                ctrl_o.pc_source = PCSRC_ALU;
                ctrl_o.pc_write  = 1'b1;
                next_state_o     = S_ID;
            end
            S_ID: begin
                // Speculative branch target into ALUOut.
                ctrl_o.alu_src_a = SRCA_PC;
                ctrl_o.alu_src_b = SRCB_IMM_S2;
                ctrl_o.ext_op    = 1'b1;
                ctrl_o.alu_op    = alu_op(1'b0, ALU_ADD);
                if (is_legal(opcode_i, funct_i)) begin
                    next_state_o = S_EX;
                end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    next_state_o = S_TRAP;
`else
                    next_state_o = S_IF;
`endif
                end
            end
            S_EX: begin
                case (opcode_i)
                    OP_RTYPE: begin
                        if ((funct_i == FN_JR) || (funct_i == FN_JALR)) begin
                            ctrl_o.pc_source = PCSRC_RS;
                            ctrl_o.pc_write  = 1'b1;
                            if (funct_i == FN_JALR) begin
                                // PC already holds PC+4 from IF.
                                ctrl_o.reg_write  = 1'b1;
                                ctrl_o.reg_dst    = DST_RD;
                                ctrl_o.mem_to_reg = M2R_PC;
                            end
                        end else if (is_r_alu(funct_i)) begin
                            ctrl_o.alu_src_a = is_shift(funct_i) ? SRCA_SHAMT : SRCA_RS;
                            ctrl_o.alu_src_b = SRCB_RT;
                            ctrl_o.alu_op    = alu_op(1'b0, ALU_RTYPE);
                            next_state_o     = S_WB;
                        end
                    end
                    OP_LW, OP_SW: begin
                        ctrl_o.alu_src_a = SRCA_RS;
                        ctrl_o.alu_src_b = SRCB_IMM;
                        ctrl_o.ext_op    = 1'b1;
                        ctrl_o.alu_op    = alu_op(1'b0, ALU_ADD);
                        next_state_o     = S_MEM;
                    end
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_SLTI, OP_SLTIU: begin
                        ctrl_o.alu_src_a = SRCA_RS;
                        ctrl_o.alu_src_b = SRCB_IMM;
                        ctrl_o.ext_op    = (opcode_i != OP_ANDI);
                        ctrl_o.alu_op    = imm_alu_op(opcode_i);
                        next_state_o     = S_WB;
                    end
                    OP_LUI: begin
                        ctrl_o.alu_src_a = SRCA_RS;
                        ctrl_o.alu_src_b = SRCB_IMM;
                        ctrl_o.lui_op    = 1'b1;
                        ctrl_o.alu_op    = alu_op(1'b0, ALU_ADD);
                        next_state_o     = S_WB;
                    end
                    OP_BEQ: begin
                        ctrl_o.alu_src_a     = SRCA_RS;
                        ctrl_o.alu_src_b     = SRCB_RT;
                        ctrl_o.alu_op        = alu_op(1'b0, ALU_SUB);
                        ctrl_o.pc_source     = PCSRC_ALUOUT;
                        ctrl_o.pc_write_cond = 1'b1;
                    end
                    OP_J, OP_JAL: begin
                        ctrl_o.pc_source = PCSRC_JUMP;
                        ctrl_o.pc_write  = 1'b1;
                        if (opcode_i == OP_JAL) begin
                            ctrl_o.reg_write  = 1'b1;
                            ctrl_o.reg_dst    = DST_RA;
                            ctrl_o.mem_to_reg = M2R_PC;
                        end
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                ctrl_o.i_or_d = 1'b1;
                if (opcode_i == OP_LW) begin
                    ctrl_o.mem_read = 1'b1;
                    next_state_o    = S_WB;
                end else if (opcode_i == OP_SW) begin
                    ctrl_o.mem_write = 1'b1;
                end
            end
            S_WB: begin
                ctrl_o.reg_write = 1'b1;
                if (opcode_i == OP_LW) begin
                    ctrl_o.reg_dst    = DST_RT;
                    ctrl_o.mem_to_reg = M2R_MDR;
                end else if (opcode_i == OP_RTYPE) begin
                    ctrl_o.reg_dst    = DST_RD;
                    ctrl_o.mem_to_reg = M2R_ALUOUT;
                end else begin
                    ctrl_o.reg_dst    = DST_RT;
                    ctrl_o.mem_to_reg = M2R_ALUOUT;
                end
            end
            S_TRAP: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                // Parked until reset; every enable stays low.
                ctrl_o.illegal = 1'b1;
                next_state_o   = S_TRAP;
`else
                next_state_o   = S_IF;
`endif
            end
            default: next_state_o = S_IF;
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// rtl/multi_cycle_controller.sv - multi-cycle MIPS main control FSM (top)
// Purpose: holds the state register and reset; decode is in controller_decode.
// Ports:   clk, reset (sync, active-high); bus (master modport): OpCode/Funct in,
//          all datapath selects, write enables and Illegal out.
// Macro:   CTRL_ILLEGAL_TRAP_EN enables the illegal-instruction trap state.
module multi_cycle_controller
    import ctrl_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    multi_cycle_controller_if.master   bus
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_dec;
    ctrl_t  ctrl_out;

    controller_decode u_decode (
        .state_i      (state_q),
        .opcode_i     (bus.OpCode),
        .funct_i      (bus.Funct),
        .ctrl_o       (ctrl_dec),
        .next_state_o (state_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are zeroed combinationally while reset is high so that no write
    // enable fires in a reset cycle, whatever state the FSM was in.
    assign ctrl_out = reset ? '0 : ctrl_dec;

    assign bus.PCWrite     = ctrl_out.pc_write;
    assign bus.PCWriteCond = ctrl_out.pc_write_cond;
    assign bus.IorD        = ctrl_out.i_or_d;
    assign bus.MemRead     = ctrl_out.mem_read;
    assign bus.MemWrite    = ctrl_out.mem_write;
    assign bus.IRWrite     = ctrl_out.ir_write;
    assign bus.MemtoReg    = ctrl_out.mem_to_reg;
    assign bus.RegDst      = ctrl_out.reg_dst;
    assign bus.RegWrite    = ctrl_out.reg_write;
    assign bus.ExtOp       = ctrl_out.ext_op;
    assign bus.LuiOp       = ctrl_out.lui_op;
    assign bus.ALUSrcA     = ctrl_out.alu_src_a;
    assign bus.ALUSrcB     = ctrl_out.alu_src_b;
    assign bus.ALUOp       = ctrl_out.alu_op;
    assign bus.PCSource    = ctrl_out.pc_source;
    assign bus.Illegal     = ctrl_out.illegal;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb/tb_multi_cycle_controller.sv - self-checking bench for multi_cycle_controller
module tb_multi_cycle_controller;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic [1:0] m2r;
        logic [1:0] rdst;
        logic       rw;
        logic       ext;
        logic       lui;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [3:0] aluop;
        logic [1:0] pcsrc;
        logic       ill;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         len;
        ctl_t       ex;
        string      name;
    } vec_t;

    localparam int K_R    = 0;
    localparam int K_SH   = 1;
    localparam int K_LW   = 2;
    localparam int K_SW   = 3;
    localparam int K_IMM  = 4;
    localparam int K_LUI  = 5;
    localparam int K_BEQ  = 6;
    localparam int K_J    = 7;
    localparam int K_JAL  = 8;
    localparam int K_JR   = 9;
    localparam int K_JALR = 10;
    localparam int K_BAD  = 11;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    multi_cycle_controller_if bus ();
    multi_cycle_controller dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Instruction class from the ISA tables.
    function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: begin
                if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) return K_SH;
                if (fn == 6'h08) return K_JR;
                if (fn == 6'h09) return K_JALR;
                if ((fn >= 6'h20 && fn <= 6'h27) || fn == 6'h2A || fn == 6'h2B) return K_R;
                return K_BAD;
            end
            6'h02: return K_J;
            6'h03: return K_JAL;
            6'h04: return K_BEQ;
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C: return K_IMM;
            6'h0F: return K_LUI;
            6'h23: return K_LW;
            6'h2B: return K_SW;
            default: return K_BAD;
        endcase
    endfunction

    function automatic int inst_len(input logic [5:0] op, input logic [5:0] fn);
        case (kind(op, fn))
            K_LW: return 5;
            K_SW, K_R, K_SH, K_IMM, K_LUI: return 4;
            K_BAD: return 2;
            default: return 3;
        endcase
    endfunction

    // Expected controls for cycle ph (0 = fetch) of an instruction.
    function automatic ctl_t model(input logic [5:0] op, input logic [5:0] fn, input int ph);
        ctl_t c;
        int   k;
        c = '0;
        k = kind(op, fn);
        if (ph == 0) begin
            c.pcw = 1; c.mrd = 1; c.irw = 1; c.srcb = 2'd1;
        end else if (ph == 1) begin
            c.srcb = 2'd3; c.ext = 1;
        end else if (ph == 2) begin
            case (k)
                K_R, K_SH: begin
                    c.srca = (k == K_SH) ? 2'd2 : 2'd1; c.aluop = 4'b0010;
                end
                K_LW, K_SW: begin
                    c.srca = 2'd1; c.srcb = 2'd2; c.ext = 1;
                end
                K_IMM: begin
                    c.srca = 2'd1; c.srcb = 2'd2; c.ext = (op != 6'h0C);
                    case (op)
                        6'h09: c.aluop = 4'b1101;
                        6'h0C: c.aluop = 4'b0011;
                        6'h0A: c.aluop = 4'b0100;
                        6'h0B: c.aluop = 4'b1100;
                        default: c.aluop = 4'b0000;
                    endcase
                end
                K_LUI: begin
                    c.srca = 2'd1; c.srcb = 2'd2; c.lui = 1;
                end
                K_BEQ: begin
                    c.srca = 2'd1; c.aluop = 4'b0001; c.pcsrc = 2'd1; c.pcwc = 1;
                end
                K_J, K_JAL: begin
                    c.pcsrc = 2'd2; c.pcw = 1;
                    if (k == K_JAL) begin c.rw = 1; c.rdst = 2'd2; c.m2r = 2'd2; end
                end
                K_JR, K_JALR: begin
                    c.pcsrc = 2'd3; c.pcw = 1;
                    if (k == K_JALR) begin c.rw = 1; c.rdst = 2'd1; c.m2r = 2'd2; end
                end
                default: ;
            endcase
        end else if (ph == 3 && k == K_LW) begin
            c.mrd = 1; c.iord = 1;
        end else if (ph == 3 && k == K_SW) begin
            c.mwr = 1; c.iord = 1;
        end else begin
            c.rw = 1;
            c.m2r = (k == K_LW) ? 2'd1 : 2'd0;
            c.rdst = (k == K_R || k == K_SH) ? 2'd1 : 2'd0;
        end
        return c;
    endfunction

    function automatic ctl_t mkx(input logic [3:0] aluop, input logic [1:0] srca,
                                 input logic [1:0] srcb, input logic ext, input logic lui,
                                 input logic [1:0] pcsrc, input logic pcw, input logic pcwc,
                                 input logic rw, input logic [1:0] rdst, input logic [1:0] m2r);
        ctl_t c;
        c = '0;
        c.aluop = aluop; c.srca = srca; c.srcb = srcb; c.ext = ext; c.lui = lui;
        c.pcsrc = pcsrc; c.pcw = pcw; c.pcwc = pcwc; c.rw = rw; c.rdst = rdst; c.m2r = m2r;
        return c;
    endfunction

    function automatic ctl_t sample();
        ctl_t c;
        c.pcw = bus.PCWrite;   c.pcwc = bus.PCWriteCond; c.iord = bus.IorD;
        c.mrd = bus.MemRead;   c.mwr = bus.MemWrite;     c.irw = bus.IRWrite;
        c.m2r = bus.MemtoReg;  c.rdst = bus.RegDst;      c.rw = bus.RegWrite;
        c.ext = bus.ExtOp;     c.lui = bus.LuiOp;        c.srca = bus.ALUSrcA;
        c.srcb = bus.ALUSrcB;  c.aluop = bus.ALUOp;      c.pcsrc = bus.PCSource;
        c.ill = bus.Illegal;
        return c;
    endfunction

    task automatic check(input string name, input ctl_t exp);
        ctl_t act;
        act = sample();
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1 of a fetch cycle; runs 'len' cycles of one instruction.
    task automatic run_inst(input logic [5:0] op, input logic [5:0] fn, input int len,
                            input bit use_ex, input ctl_t ex, input string name);
        for (int ph = 0; ph < len; ph++) begin
            if (ph == 0) begin
                bus.OpCode = 6'($urandom);
                bus.Funct  = 6'($urandom);
            end else if (ph == 1) begin
                bus.OpCode = op;
                bus.Funct  = fn;
            end
            @(negedge clk);
            if (ph == 2 && use_ex) check($sformatf("%s EX", name), ex);
            else check($sformatf("%s ph%0d", name, ph), model(op, fn, ph));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_cycle(input string name);
        ctl_t z;
        z = '0;
        reset = 1'b1;
        @(negedge clk);
        check(name, z);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    vec_t       tbl[17];
    logic [5:0] ops[12] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09,
                            6'h0A, 6'h0B, 6'h0C, 6'h0F, 6'h23, 6'h2B};
    logic [5:0] rfn[15] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21, 6'h22,
                            6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

    initial begin
        ctl_t       zero_c;
        ctl_t       trap_c;
        logic [5:0] rop;
        logic [5:0] rf;

        zero_c = '0;
        trap_c = '0;
        trap_c.ill = 1'b1;

        tbl[0]  = '{6'h23, 6'h00, 5, mkx(4'b0000, 2'd1, 2'd2, 1, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0), "lw"};
        tbl[1]  = '{6'h2B, 6'h00, 4, mkx(4'b0000, 2'd1, 2'd2, 1, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0), "sw"};
        tbl[2]  = '{6'h00, 6'h20, 4, mkx(4'b0010, 2'd1, 2'd0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0), "add"};
        tbl[3]  = '{6'h00, 6'h00, 4, mkx(4'b0010, 2'd2, 2'd0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0), "sll"};
        tbl[4]  = '{6'h00, 6'h03, 4, mkx(4'b0010, 2'd2, 2'd0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0), "sra"};
        tbl[5]  = '{6'h00, 6'h2A, 4, mkx(4'b0010, 2'd1, 2'd0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0), "slt"};
        tbl[6]  = '{6'h08, 6'h00, 4, mkx(4'b0000, 2'd1, 2'd2, 1, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0), "addi"};
        tbl[7]  = '{6'h09, 6'h00, 4, mkx(4'b1101, 2'd1, 2'd2, 1, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0), "addiu"};
        tbl[8]  = '{6'h0C, 6'h00, 4, mkx(4'b0011, 2'd1, 2'd2, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0), "andi"};
        tbl[9]  = '{6'h0A, 6'h00, 4, mkx(4'b0100, 2'd1, 2'd2, 1, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0), "slti"};
        tbl[10] = '{6'h0B, 6'h00, 4, mkx(4'b1100, 2'd1, 2'd2, 1, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0), "sltiu"};
        tbl[11] = '{6'h0F, 6'h00, 4, mkx(4'b0000, 2'd1, 2'd2, 0, 1, 2'd0, 0, 0, 0, 2'd0, 2'd0), "lui"};
        tbl[12] = '{6'h04, 6'h00, 3, mkx(4'b0001, 2'd1, 2'd0, 0, 0, 2'd1, 0, 1, 0, 2'd0, 2'd0), "beq"};
        tbl[13] = '{6'h02, 6'h00, 3, mkx(4'b0000, 2'd0, 2'd0, 0, 0, 2'd2, 1, 0, 0, 2'd0, 2'd0), "j"};
        tbl[14] = '{6'h03, 6'h00, 3, mkx(4'b0000, 2'd0, 2'd0, 0, 0, 2'd2, 1, 0, 1, 2'd2, 2'd2), "jal"};
        tbl[15] = '{6'h00, 6'h08, 3, mkx(4'b0000, 2'd0, 2'd0, 0, 0, 2'd3, 1, 0, 0, 2'd0, 2'd0), "jr"};
        tbl[16] = '{6'h00, 6'h09, 3, mkx(4'b0000, 2'd0, 2'd0, 0, 0, 2'd3, 1, 0, 1, 2'd1, 2'd2), "jalr"};

        bus.OpCode = 6'h00;
        bus.Funct  = 6'h00;
        reset      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset%0d", i), zero_c);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 17; i++)
            run_inst(tbl[i].op, tbl[i].fn, tbl[i].len, 1'b1, tbl[i].ex, tbl[i].name);

        // Reset mid-instruction: lw in MEM, j in EX (where PCWrite would fire).
        run_inst(6'h23, 6'h00, 3, 1'b0, zero_c, "lw_abort");
        reset_cycle("reset in lw MEM");
        run_inst(6'h02, 6'h00, 2, 1'b0, zero_c, "j_abort");
        reset_cycle("reset in j EX");

`ifdef CTRL_ILLEGAL_TRAP_EN
        run_inst(6'h3F, 6'h00, 2, 1'b0, zero_c, "bad_op");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("trap hold%0d", i), trap_c);
            @(posedge clk);
            #1;
        end
        reset_cycle("trap reset");
        run_inst(6'h00, 6'h3F, 2, 1'b0, zero_c, "bad_funct");
        @(negedge clk);
        check("trap funct", trap_c);
        @(posedge clk);
        #1;
        reset_cycle("trap funct reset");
`else
        run_inst(6'h3F, 6'h00, 2, 1'b0, zero_c, "bad_op nop");
        run_inst(6'h00, 6'h3F, 2, 1'b0, zero_c, "bad_funct nop");
`endif

        for (int i = 0; i < 150; i++) begin
            rop = ops[$urandom_range(0, 11)];
            rf  = (rop == 6'h00) ? rfn[$urandom_range(0, 14)] : 6'($urandom);
`ifndef CTRL_ILLEGAL_TRAP_EN
            if ($urandom_range(0, 9) == 0) begin
                rop = ($urandom_range(0, 1) == 0) ? 6'h3F : 6'h00;
                rf  = 6'h3F;
            end
`endif
            run_inst(rop, rf, inst_len(rop, rf), 1'b0, zero_c, $sformatf("rnd%0d op%h fn%h", i, rop, rf));
        end

        run_inst(6'h23, 6'h00, 1, 1'b0, zero_c, "final_if");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
